// File: rtl/nios_system_nios2_mul_pipe.sv
// nios_system_nios2_mul_pipe
// Three-stage pipelined WIDTH x WIDTH integer multiplier for the Nios II
// custom datapath. Operands are split into half-width limbs. Four limb
// products are registered, then recombined into the selected product word.
// A valid/ready handshake with a global stall applies backpressure, and a
// sideband tag travels alongside each beat.
//
// Optional feature macro: NIOS_MUL_PIPE_HIGH_EN
//   defined     : MUL / MULXUU / MULXSU / MULXSS (high word, signed correction)
//   not defined : low word of the unsigned product only, for every in_op
module nios_system_nios2_mul_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int H = WIDTH / 2;

    logic               advance;

    logic               s1_valid;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_valid;
    logic [WIDTH-1:0]   s2_ll;
    logic [WIDTH-1:0]   s2_lh;
    logic [WIDTH-1:0]   s2_hl;
    logic [TAG_W-1:0]   s2_tag;

    logic [WIDTH-1:0]   pp_ll;
    logic [WIDTH-1:0]   pp_lh;
    logic [WIDTH-1:0]   pp_hl;
    logic [WIDTH:0]     mid_sum;
    logic [2*WIDTH-1:0] hh_term;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   result_word;

    // Any valid result leaving, or an empty output slot, lets every stage move.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Unsigned limb products; each fits exactly in WIDTH bits.
    assign pp_ll = {{H{1'b0}}, s1_a[H-1:0]}     * {{H{1'b0}}, s1_b[H-1:0]};
    assign pp_lh = {{H{1'b0}}, s1_a[H-1:0]}     * {{H{1'b0}}, s1_b[WIDTH-1:H]};
    assign pp_hl = {{H{1'b0}}, s1_a[WIDTH-1:H]} * {{H{1'b0}}, s1_b[H-1:0]};

    // The middle sum keeps its carry bit so it can ripple into the high word.
    assign mid_sum = {1'b0, s2_lh} + {1'b0, s2_hl};
    assign prod    = {{WIDTH{1'b0}}, s2_ll}
                   + ({{(WIDTH-1){1'b0}}, mid_sum} << H)
                   + hh_term;

`ifdef NIOS_MUL_PIPE_HIGH_EN
    logic [1:0]       s1_op;
    logic [1:0]       s2_op;
    logic             s2_sa;
    logic             s2_sb;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;
    logic [WIDTH-1:0] s2_hh;
    logic [WIDTH-1:0] pp_hh;
    logic [WIDTH-1:0] high_word;

    assign pp_hh   = {{H{1'b0}}, s1_a[WIDTH-1:H]} * {{H{1'b0}}, s1_b[WIDTH-1:H]};
    assign hh_term = {s2_hh, {WIDTH{1'b0}}};

    // Signed operands are handled by subtracting the other operand from the
    // unsigned high word wherever a sign bit was set.
    assign high_word   = prod[2*WIDTH-1:WIDTH]
                       - (s2_sa ? s2_b : {WIDTH{1'b0}})
                       - (s2_sb ? s2_a : {WIDTH{1'b0}});
    assign result_word = (s2_op == 2'b00) ? prod[WIDTH-1:0] : high_word;

    // Opcode capture alongside the operands in stage 1.
    always_ff @(posedge clk) begin
        if (advance) begin
            s1_op <= in_op;
        end
    end

    // High limb product, sign flags and raw operands for the correction step.
    always_ff @(posedge clk) begin
        if (advance) begin
            s2_hh <= pp_hh;
            s2_op <= s1_op;
            s2_sa <= s1_op[1] & s1_a[WIDTH-1];
            s2_sb <= (s1_op == 2'b11) & s1_b[WIDTH-1];
            s2_a  <= s1_a;
            s2_b  <= s1_b;
        end
    end
`else
    logic unused_op;
    logic unused_prod_hi;

    assign hh_term        = {2*WIDTH{1'b0}};
    assign result_word    = prod[WIDTH-1:0];
    assign unused_op      = ^in_op;
    assign unused_prod_hi = ^prod[2*WIDTH-1:WIDTH];
`endif

    // Stage 1: capture the offered beat; a bubble enters when in_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_tag   <= in_tag;
        end
    end

    // Stage 2: register the three always-present limb products and the tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_ll    <= pp_ll;
            s2_lh    <= pp_lh;
            s2_hl    <= pp_hl;
            s2_tag   <= s1_tag;
        end
    end

    // Stage 3: registered result; data only updates for real beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_result <= {WIDTH{1'b0}};
            out_tag    <= {TAG_W{1'b0}};
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_result <= result_word;
                out_tag    <= s2_tag;
            end
        end
    end

endmodule

// File: tb/tb_nios_system_nios2_mul_pipe.sv
// tb_nios_system_nios2_mul_pipe
// Self-checking bench for the pipelined multiplier. Expected results come
// from a 64-bit arithmetic reference model (or literal constants), matched
// against outputs in acceptance order through a scoreboard queue.
// Honours NIOS_MUL_PIPE_HIGH_EN in the same way as the design.
module tb_nios_system_nios2_mul_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t sb[$];

    nios_system_nios2_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    // Free-running clock and a count of rising edges seen so far.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: sign- or zero-extend to 64 bits, multiply, pick a word.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] op);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = op[1]          ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'b11)  ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
`ifdef NIOS_MUL_PIPE_HIGH_EN
        return (op == 2'b00) ? p[31:0] : p[63:32];
`else
        return p[31:0];
`endif
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Apply one cycle of inputs; called just after a falling edge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [3:0] tag, input logic rdy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = tag;
        out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b1);
        end
        checks++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: valid %b result %h tag %h, expected 0 0 0",
                     out_valid, out_result, out_tag);
        end
        reset = 1'b0;
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b0);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: in_ready %b out_valid %b, expected 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_directed_ops();
        logic [31:0] va [9];
        logic [31:0] vb [9];
        logic [1:0]  vop [9];
        logic [31:0] vexp [9];
        int idx = 0;
        int got = 0;
        exp_t e;
        va  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0001_0000, 32'h0001_0000,
                32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        vb  = va;
        vop = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b01, 2'b10};
`ifdef NIOS_MUL_PIPE_HIGH_EN
        vexp = '{32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000,
                 32'h0000_0000, 32'h0000_0001,
                 32'h4000_0000, 32'h4000_0000, 32'hC000_0000};
`else
        vexp = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                 32'h0000_0000, 32'h0000_0000,
                 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
`endif
        sb.delete();
        for (int k = 0; k < 60 && got < 9; k++) begin
            @(negedge clk);
            if (idx < 9) drive(1'b1, va[idx], vb[idx], vop[idx], 4'(idx), 1'b1);
            else         drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b1);
            if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL directed_extra: result %h tag %0d with nothing pending",
                             out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag || cyc - e.acc != 3) begin
                        errors++;
                        $display("[TB] FAIL directed_beat: result %h tag %0d latency %0d, expected %h tag %0d latency 3",
                                 out_result, out_tag, cyc - e.acc, e.res, e.tag);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{res: vexp[idx], tag: 4'(idx), acc: cyc});
                idx++;
            end
        end
        checks++;
        if (got != 9) begin
            errors++;
            $display("[TB] FAIL directed_count: got %0d results, expected 9", got);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a [6];
        logic [31:0] b [6];
        logic [1:0]  op [6];
        logic [31:0] held_r = '0;
        logic [3:0]  held_t = '0;
        bit holding = 0;
        bit started = 0;
        int stall = 0;
        int idx = 0;
        int got = 0;
        logic rdy;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            a[i]  = rand_operand();
            b[i]  = rand_operand();
            op[i] = 2'($urandom_range(0, 3));
        end
        sb.delete();
        for (int k = 0; k < 100 && got < 6; k++) begin
            @(negedge clk);
            if (!started && out_valid) begin
                started = 1;
                stall   = 5;
            end
            rdy = (stall == 0);
            if (idx < 6) drive(1'b1, a[idx], b[idx], op[idx], 4'(idx), rdy);
            else         drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, rdy);
            if (stall > 0) begin
                checks++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL bp_stall: in_ready %b out_valid %b, expected 0 1",
                             in_ready, out_valid);
                end
                if (holding) begin
                    checks++;
                    if (out_result !== held_r || out_tag !== held_t) begin
                        errors++;
                        $display("[TB] FAIL bp_hold: result %h tag %0d, expected %h tag %0d",
                                 out_result, out_tag, held_r, held_t);
                    end
                end
                holding = 1;
                held_r  = out_result;
                held_t  = out_tag;
                stall--;
            end else if (out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bp_extra: result %h tag %0d with nothing pending",
                             out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag) begin
                        errors++;
                        $display("[TB] FAIL bp_beat: result %h tag %0d, expected %h tag %0d",
                                 out_result, out_tag, e.res, e.tag);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back('{res: ref_result(a[idx], b[idx], op[idx]), tag: 4'(idx), acc: cyc});
                idx++;
            end
        end
        repeat (4) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b1);
            if (out_valid) got++;
        end
        checks++;
        if (got != 6 || !started) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d results, expected 6", got);
        end
    endtask

    task automatic test_random_stream();
        localparam int N = 80;
        int idx = 0;
        int got = 0;
        bit was_stalled = 0;
        logic [31:0] held_r = '0;
        logic [3:0]  held_t = '0;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic v;
        logic rdy;
        exp_t e;
        sb.delete();
        for (int k = 0; k < 2000 && got < N; k++) begin
            @(negedge clk);
            rdy = ($urandom_range(0, 9) < 7);
            v   = (idx < N) && ($urandom_range(0, 3) != 0);
            a   = rand_operand();
            b   = rand_operand();
            op  = 2'($urandom_range(0, 3));
            drive(v, a, b, op, 4'(idx), rdy);
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("[TB] FAIL rand_ready: in_ready %b, expected %b", in_ready, !out_valid || out_ready);
            end
            if (was_stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_result !== held_r || out_tag !== held_t) begin
                    errors++;
                    $display("[TB] FAIL rand_hold: valid %b result %h tag %0d, expected 1 %h tag %0d",
                             out_valid, out_result, out_tag, held_r, held_t);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra: result %h tag %0d with nothing pending",
                             out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    if (out_result !== e.res || out_tag !== e.tag) begin
                        errors++;
                        $display("[TB] FAIL rand_beat: result %h tag %0d, expected %h tag %0d",
                                 out_result, out_tag, e.res, e.tag);
                    end
                end
                got++;
            end
            was_stalled = out_valid && !out_ready;
            held_r      = out_result;
            held_t      = out_tag;
            if (in_valid && in_ready) begin
                sb.push_back('{res: ref_result(a, b, op), tag: 4'(idx), acc: cyc});
                idx++;
            end
        end
        checks++;
        if (got != N) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d results, expected %0d", got, N);
        end
    endtask

    task automatic test_reset_midflight();
        int acc_cyc = 0;
        bit seen = 0;
        @(negedge clk);
        drive(1'b1, 32'd3, 32'd5, 2'b00, 4'h1, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_accept: in_ready %b, expected 1", in_ready);
        end
        @(negedge clk);
        drive(1'b1, 32'd9, 32'd9, 2'b00, 4'h2, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_flush: out_valid %b result %h, expected 0", out_valid, out_result);
            end
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b1);
        end
        @(negedge clk);
        drive(1'b1, 32'd7, 32'd6, 2'b00, 4'hA, 1'b1);
        acc_cyc = cyc;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0, 1'b1);
            if (out_valid) begin
                seen = 1;
                checks++;
                if (out_result !== 32'd42 || out_tag !== 4'hA || cyc - acc_cyc != 3) begin
                    errors++;
                    $display("[TB] FAIL midrst_fresh: result %0d tag %h latency %0d, expected 42 tag a latency 3",
                             out_result, out_tag, cyc - acc_cyc);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL midrst_timeout: out_valid never rose, expected result 42");
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_directed_ops();
        test_backpressure();
        test_random_stream();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
